mcu_run_ctrl: RTL and testbench

Parametrised run controller that sits between the board clock/reset and the single-cycle MCU core. It replaces free-running bring-up with a stretched core reset, a gated core clock-enable, and selectable run modes: free, single-step, run-N-cycles and run-to-breakpoint. It also holds a write-back trace FIFO for post-halt inspection by the LCD/debug logic.

---
 rtl/mcu_run_ctrl.sv | 147 ++++++++++++++
 tb/tb_mcu_run_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_run_ctrl.sv
// Run controller for the MCU core: reset stretch, gated clock-enable,
// free/step/count/break run modes and a write-back trace FIFO.
module mcu_run_ctrl #(
  parameter int DATA_WIDTH   = 16,
  parameter int TRACE_DEPTH  = 16,
  parameter int RESET_CYCLES = 50,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           clear,
  input  logic [1:0]                     mode,
  input  logic                           start,
  input  logic                           stop,
  input  logic                           step,
  input  logic [CNT_WIDTH-1:0]           run_count,
  input  logic [DATA_WIDTH-1:0]          break_value,
  input  logic [DATA_WIDTH-1:0]          wb_data,
  input  logic                           wb_valid,
  output logic                           core_nclear,
  output logic                           core_en,
  output logic                           halted,
  output logic [CNT_WIDTH-1:0]           cycle_count,
  input  logic                           trace_rd,
  output logic [DATA_WIDTH-1:0]          trace_data,
  output logic                           trace_valid,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow
);

  localparam int AW = $clog2(TRACE_DEPTH);
  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW+1)'(TRACE_DEPTH);

  typedef enum logic [1:0] {
    S_RST, S_IDLE, S_RUN, S_HALT
  } state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         hold_q, hold_d;
  logic [1:0]            mode_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] brk_q;
  logic [CNT_WIDTH-1:0]  cyc_q;

  logic [DATA_WIDTH-1:0] mem_q [TRACE_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           cnt_q;
  logic                  ovf_q;

  logic start_ok, push, pop, full, wr;
  logic cnt_done, brk_hit;

  assign start_ok = start &&
                    (state_q == S_IDLE || state_q == S_HALT);
  assign full     = (cnt_q == FULL_CNT);
  assign push     = wb_valid && core_en;
  assign pop      = trace_rd && (cnt_q != '0);
  assign wr       = push && (!full || pop);
  assign cnt_done = (mode_q == 2'd2) && core_en &&
                    (rem_q == CNT_WIDTH'(1));
  assign brk_hit  = (mode_q == 2'd3) && push &&
                    (wb_data == brk_q);

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_RST;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    case (state_q)
      S_RST: begin
        if (hold_q == HOLD_LAST) state_d = S_IDLE;
        else                     hold_d  = hold_q + 1'b1;
      end
      S_IDLE, S_HALT: begin
        if (start) begin
          if (mode == 2'd2 && run_count == '0)
            state_d = S_HALT;
          else
            state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (stop || cnt_done || brk_hit) state_d = S_HALT;
      end
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    core_nclear = (state_q != S_RST);
    halted      = (state_q == S_HALT);
    core_en     = (state_q == S_RUN) &&
                  ((mode_q != 2'd1) || step);
  end

  // Run parameters are latched on start so mid-run input changes are inert.
  always_ff @(posedge clk) begin
    if (clear) begin
      mode_q <= '0;
      rem_q  <= '0;
      brk_q  <= '0;
      cyc_q  <= '0;
    end else if (start_ok) begin
      mode_q <= mode;
      rem_q  <= run_count;
      brk_q  <= break_value;
      cyc_q  <= '0;
    end else if (core_en) begin
      if (cyc_q != '1)     cyc_q <= cyc_q + 1'b1;
      if (mode_q == 2'd2)  rem_q <= rem_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
      if (push && full && !pop) ovf_q <= 1'b1;
    end
  end

  assign cycle_count    = cyc_q;
  assign trace_data     = mem_q[rd_ptr_q];
  assign trace_valid    = (cnt_q != '0);
  assign trace_count    = cnt_q;
  assign trace_overflow = ovf_q;

endmodule

// File: tb/tb_mcu_run_ctrl.sv
// Self-checking bench for mcu_run_ctrl with a trace scoreboard queue.
module tb_mcu_run_ctrl;

  localparam int DW = 16;
  localparam int CW = 16;
  localparam int TD = 4;
  localparam int RC = 50;

  logic          clk = 1'b0;
  logic          clear, start, stop, step, wb_valid, trace_rd;
  logic [1:0]    mode;
  logic [CW-1:0] run_count, cycle_count;
  logic [DW-1:0] break_value, wb_data, trace_data;
  logic          core_nclear, core_en, halted;
  logic          trace_valid, trace_overflow;
  logic [$clog2(TD):0] trace_count;

  int npass = 0;
  int ntot  = 0;
  logic [DW-1:0] sb [$];

  mcu_run_ctrl #(
    .DATA_WIDTH(DW), .TRACE_DEPTH(TD),
    .RESET_CYCLES(RC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .clear(clear), .mode(mode),
    .start(start), .stop(stop), .step(step),
    .run_count(run_count),
    .break_value(break_value),
    .wb_data(wb_data), .wb_valid(wb_valid),
    .core_nclear(core_nclear), .core_en(core_en),
    .halted(halted), .cycle_count(cycle_count),
    .trace_rd(trace_rd), .trace_data(trace_data),
    .trace_valid(trace_valid),
    .trace_count(trace_count),
    .trace_overflow(trace_overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic count_hold(input string nm);
    int n = 0;
    while (core_nclear == 1'b0 && n < 200) begin
      n++;
      tick();
    end
    ntot++;
    if (n !== RC) $display("FAIL %s hold cycles got %0d want %0d", nm, n, RC);
    else npass++;
  endtask

  task automatic drain(input string nm);
    int g = 0;
    logic [DW-1:0] exp;
    while (trace_valid && g < 20) begin
      g++;
      ntot++;
      if (sb.size() == 0) begin
        $display("FAIL %s unexpected entry got %h", nm, trace_data);
      end else begin
        exp = sb.pop_front();
        if (trace_data !== exp)
          $display("FAIL %s data got %h want %h", nm, trace_data, exp);
        else npass++;
      end
      trace_rd = 1'b1;
      tick();
      trace_rd = 1'b0;
    end
    ntot++;
    if (sb.size() != 0 || trace_count !== 0)
      $display("FAIL %s leftover got sb=%0d cnt=%0d want 0", nm, sb.size(), trace_count);
    else npass++;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (3) tick();
    ntot++;
    if ({core_nclear, core_en, halted, trace_valid, trace_overflow} !== 5'b0 ||
        cycle_count !== 0 || trace_count !== 0)
      $display("FAIL reset_vals got nclr=%b en=%b h=%b cyc=%0d tc=%0d ovf=%b want zeros",
               core_nclear, core_en, halted, cycle_count, trace_count, trace_overflow);
    else npass++;
    clear = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ntot++;
    if (core_nclear !== 1'b0) $display("FAIL reset_first got %b want 0", core_nclear);
    else npass++;
    // one hold cycle already elapsed above
    begin
      int n = 1;
      while (core_nclear == 1'b0 && n < 200) begin
        n++;
        tick();
      end
      ntot++;
      if (n !== RC) $display("FAIL reset_hold got %0d want %0d", n, RC);
      else npass++;
    end
    tick();
    ntot++;
    if (core_en !== 1'b0 || halted !== 1'b0 || core_nclear !== 1'b1)
      $display("FAIL reset_idle got en=%b h=%b nclr=%b want 0 0 1", core_en, halted, core_nclear);
    else npass++;
  endtask

  task automatic test_count();
    int en = 0;
    int k = 0;
    mode = 2'd2;
    run_count = 5;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_count = 99;
    while (!halted && k < 20) begin
      if (core_en) en++;
      k++;
      tick();
    end
    ntot++;
    if (en !== 5) $display("FAIL count_en got %0d want 5", en);
    else npass++;
    ntot++;
    if (halted !== 1'b1 || core_en !== 1'b0 || cycle_count !== 5)
      $display("FAIL count_halt got h=%b en=%b cyc=%0d want 1 0 5", halted, core_en, cycle_count);
    else npass++;
    run_count = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    ntot++;
    if (halted !== 1'b1 || core_en !== 1'b0 || cycle_count !== 0)
      $display("FAIL count_zero got h=%b en=%b cyc=%0d want 1 0 0", halted, core_en, cycle_count);
    else npass++;
    tick();
    ntot++;
    if (halted !== 1'b1 || core_en !== 1'b0)
      $display("FAIL count_zero_hold got h=%b en=%b want 1 0", halted, core_en);
    else npass++;
  endtask

  task automatic test_break();
    logic [DW-1:0] vals [4];
    vals[0] = 16'h0001;
    vals[1] = 16'h0002;
    vals[2] = 16'h00A5;
    vals[3] = 16'h0007;
    mode = 2'd3;
    break_value = 16'h00A5;
    start = 1'b1;
    tick();
    start = 1'b0;
    break_value = 16'h0002;
    wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wb_data = vals[i];
      sb.push_back(vals[i]);
      ntot++;
      if (core_en !== 1'b1) $display("FAIL break_en%0d got %b want 1", i, core_en);
      else npass++;
      tick();
    end
    wb_data = vals[3];
    ntot++;
    if (core_en !== 1'b0 || halted !== 1'b1)
      $display("FAIL break_halt got en=%b h=%b want 0 1", core_en, halted);
    else npass++;
    tick();
    wb_valid = 1'b0;
    ntot++;
    if (trace_count !== 3 || cycle_count !== 3)
      $display("FAIL break_trace got tc=%0d cyc=%0d want 3 3", trace_count, cycle_count);
    else npass++;
    drain("break_drain");
  endtask

  task automatic test_step();
    mode = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    ntot++;
    if (core_en !== 1'b0) $display("FAIL step_idle got %b want 0", core_en);
    else npass++;
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      wb_valid = 1'b1;
      wb_data = DW'(16'h10 + i);
      sb.push_back(DW'(16'h10 + i));
      tick();
      step = 1'b0;
      wb_valid = 1'b0;
      tick();
    end
    ntot++;
    if (cycle_count !== 3 || trace_count !== 3 || halted !== 1'b0)
      $display("FAIL step_counts got cyc=%0d tc=%0d h=%b want 3 3 0", cycle_count, trace_count, halted);
    else npass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ntot++;
    if (halted !== 1'b1) $display("FAIL step_stop got %b want 1", halted);
    else npass++;
    drain("step_drain");
  endtask

  task automatic test_overflow();
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wb_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wb_data = DW'(16'h21 + i);
      if (i < TD) sb.push_back(DW'(16'h21 + i));
      tick();
    end
    wb_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    ntot++;
    if (trace_count !== TD || trace_overflow !== 1'b1 || halted !== 1'b1)
      $display("FAIL ovf_full got tc=%0d ovf=%b h=%b want 4 1 1", trace_count, trace_overflow, halted);
    else npass++;
    start = 1'b1;
    tick();
    start = 1'b0;
    trace_rd = 1'b1;
    wb_valid = 1'b1;
    wb_data = 16'h0030;
    ntot++;
    if (trace_data !== sb[0])
      $display("FAIL ovf_head got %h want %h", trace_data, sb[0]);
    else npass++;
    void'(sb.pop_front());
    sb.push_back(16'h0030);
    tick();
    trace_rd = 1'b0;
    wb_valid = 1'b0;
    ntot++;
    if (trace_count !== TD || trace_overflow !== 1'b1)
      $display("FAIL ovf_pushpop got tc=%0d ovf=%b want 4 1", trace_count, trace_overflow);
    else npass++;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain("ovf_drain");
    ntot++;
    if (trace_overflow !== 1'b1) $display("FAIL ovf_sticky got %b want 1", trace_overflow);
    else npass++;
  endtask

  task automatic test_clear_midrun();
    mode = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wb_valid = 1'b1;
    wb_data = 16'h0005;
    tick();
    wb_valid = 1'b0;
    ntot++;
    if (core_en !== 1'b1 || trace_count !== 1)
      $display("FAIL clr_pre got en=%b tc=%0d want 1 1", core_en, trace_count);
    else npass++;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    ntot++;
    if (core_en !== 1'b0 || core_nclear !== 1'b0 || trace_count !== 0 ||
        trace_valid !== 1'b0 || trace_overflow !== 1'b0 || cycle_count !== 0)
      $display("FAIL clr_post got en=%b nclr=%b tc=%0d ovf=%b cyc=%0d want 0 0 0 0 0",
               core_en, core_nclear, trace_count, trace_overflow, cycle_count);
    else npass++;
    count_hold("clr_hold");
    ntot++;
    if (core_en !== 1'b0 || halted !== 1'b0)
      $display("FAIL clr_idle got en=%b h=%b want 0 0", core_en, halted);
    else npass++;
  endtask

  initial begin
    clear = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    step = 1'b0;
    mode = 2'd0;
    run_count = '0;
    break_value = '0;
    wb_data = '0;
    wb_valid = 1'b0;
    trace_rd = 1'b0;
    #1;
    test_reset();
    test_count();
    test_break();
    test_step();
    test_overflow();
    test_clear_midrun();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
